// File: rtl/teatimer_gen.sv
// Tea brew timer: IDLE/RUN/PAUSE/DONE controller that renders elapsed time onto an
// NLED-pixel GRB framebuffer (B = fine progress, G = coarse progress, blinking done display).
module teatimer_gen #(
   parameter int NLED       = 16,
   parameter int LEVEL      = 255,
   parameter int DONE_LEVEL = 1,
   parameter bit BLINK      = 1'b1
) (
   input  logic                        clk,
   input  logic                        nrst,
   input  logic                        tick,
   input  logic                        sw_start,
   input  logic                        sw_stop,
   input  logic                        sw_pause,
   input  logic [2*$clog2(NLED)-1:0]   target,
   output logic [NLED*24-1:0]          framebuf,
   output logic                        running,
   output logic                        done
);

   localparam int LW = $clog2(NLED);
   localparam int TW = 2 * LW;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

   state_e              state_q, state_d;
   logic [TW-1:0]       elapsed_q, elapsed_d;
   logic [TW-1:0]       tgt_q, tgt_d;
   logic                ph_q, ph_d;
   logic [NLED*24-1:0]  framebuf_q, framebuf_d;
   logic                running_q, done_q;
   logic [LW-1:0]       fine, coarse;

   assign fine     = elapsed_q[LW-1:0];
   assign coarse   = elapsed_q[TW-1:LW];
   assign framebuf = framebuf_q;
   assign running  = running_q;
   assign done     = done_q;

   // Only the highest-priority control input acts in a cycle; the rest are dropped.
   always_comb begin
      state_d   = state_q;
      elapsed_d = elapsed_q;
      tgt_d     = tgt_q;
      ph_d      = ph_q;
      if (sw_stop) begin
         state_d   = IDLE;
         elapsed_d = '0;
      end else if (sw_start) begin
         tgt_d     = target;
         elapsed_d = '0;
         ph_d      = 1'b1;
         state_d   = (target == '0) ? DONE : RUN;
      end else if (sw_pause) begin
         if (state_q == RUN) begin
            state_d = PAUSE;
         end else if (state_q == PAUSE) begin
            state_d = RUN;
         end
      end else if (tick) begin
         if (state_q == RUN) begin
            elapsed_d = elapsed_q + 1'b1;
            if (elapsed_d == tgt_q) begin
               state_d = DONE;
            end
         end else if (state_q == DONE && BLINK) begin
            ph_d = ~ph_q;
         end
      end
   end

   // The display is rendered from the current registers, so it trails a state update by one clk.
   always_comb begin
      framebuf_d = '0;
      if (state_q == RUN || state_q == PAUSE) begin
         for (int k = 0; k < NLED; k++) begin
            if (k < int'(fine)) begin
               framebuf_d[24*k+16 +: 8] = 8'(LEVEL);
            end
            if (k < int'(coarse)) begin
               framebuf_d[24*k +: 8] = 8'(LEVEL);
            end
         end
      end else if (state_q == DONE && ph_q) begin
         for (int b = 0; b < 3*NLED; b++) begin
            framebuf_d[8*b +: 8] = 8'(DONE_LEVEL);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q    <= IDLE;
         elapsed_q  <= '0;
         tgt_q      <= '0;
         ph_q       <= 1'b1;
         framebuf_q <= '0;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         elapsed_q  <= elapsed_d;
         tgt_q      <= tgt_d;
         ph_q       <= ph_d;
         framebuf_q <= framebuf_d;
         running_q  <= (state_d == RUN);
         done_q     <= (state_d == DONE);
      end
   end

endmodule

// File: tb/tb_teatimer_gen.sv
// Bench for teatimer_gen (NLED=4): directed scenarios plus a randomized run against a
// flag-and-arithmetic reference model of the timer.
module tb_teatimer_gen;

   localparam int N     = 4;
   localparam int TW    = 4;
   localparam bit BLINK = 1'b1;

   logic            clk = 1'b0;
   logic            nrst;
   logic            tick, swStart, swStop, swPause;
   logic [TW-1:0]   target;
   logic [N*24-1:0] framebuf;
   logic            running, done;

   int checks = 0;
   int errors = 0;

   bit              mActive, mPaused, mFinished, mPh;
   int              mEl, mTgt;
   logic [N*24-1:0] mFb;

   teatimer_gen #(.NLED(N), .LEVEL(255), .DONE_LEVEL(1), .BLINK(BLINK)) dut (
      .clk(clk), .nrst(nrst), .tick(tick), .sw_start(swStart), .sw_stop(swStop),
      .sw_pause(swPause), .target(target), .framebuf(framebuf), .running(running), .done(done)
   );

   always #5 clk = ~clk;

   // Display expected for a given timer condition: B lights elapsed%N pixels, G lights elapsed/N.
   function automatic logic [N*24-1:0] fbOf(bit act, bit fin, bit p, int el);
      logic [N*24-1:0] f;
      f = '0;
      if (fin) begin
         if (p) for (int b = 0; b < 3*N; b++) f[8*b +: 8] = 8'd1;
      end else if (act) begin
         for (int k = 0; k < N; k++) begin
            if (k < el % N) f[24*k+16 +: 8] = 8'd255;
            if (k < el / N) f[24*k +: 8] = 8'd255;
         end
      end
      return f;
   endfunction

   task automatic modelUpdate();
      if (!nrst) begin
         mActive = 0; mPaused = 0; mFinished = 0; mEl = 0; mTgt = 0; mPh = 1; mFb = '0;
      end else begin
         mFb = fbOf(mActive, mFinished, mPh, mEl);
         if (swStop) begin
            mActive = 0; mPaused = 0; mFinished = 0; mEl = 0;
         end else if (swStart) begin
            mTgt = int'(target); mEl = 0; mPh = 1; mPaused = 0;
            mFinished = (mTgt == 0); mActive = (mTgt != 0);
         end else if (swPause) begin
            if (mActive) mPaused = !mPaused;
         end else if (tick) begin
            if (mActive && !mPaused) begin
               mEl++;
               if (mEl == mTgt) begin mActive = 0; mFinished = 1; end
            end else if (mFinished && BLINK) begin
               mPh = !mPh;
            end
         end
      end
   endtask

   task automatic step(input bit st, input bit sp, input bit pa, input bit tk, input logic [TW-1:0] tg);
      swStart = st; swStop = sp; swPause = pa; tick = tk; target = tg;
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
      swStart = 0; swStop = 0; swPause = 0; tick = 0;
   endtask

   task automatic test_reset();
      nrst = 0;
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 4'd5);
      checks += 3;
      if (running !== 1'b0) begin errors++; $display("[TB] FAIL reset_running got %b want 0", running); end
      if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
      if (framebuf !== '0) begin errors++; $display("[TB] FAIL reset_fb got %h want 0", framebuf); end
      nrst = 1;
      for (int i = 0; i < 3; i++) begin
         step(0, 0, i == 1, 1, 0);
         checks += 2;
         if (running !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL idle_flags cycle %0d got %b%b want 00", i, running, done); end
         if (framebuf !== '0) begin errors++; $display("[TB] FAIL idle_fb cycle %0d got %h want 0", i, framebuf); end
      end
   endtask

   task automatic test_countdown();
      logic [N*24-1:0] want3, want5, wantAll1;
      want3    = {24'h0, 24'hFF0000, 24'hFF0000, 24'hFF0000};
      want5    = {72'h0, 24'hFF00FF};
      wantAll1 = {12{8'h01}};
      step(1, 0, 0, 0, 4'd6);
      for (int i = 1; i <= 6; i++) begin
         step(0, 0, 0, 1, 0);
         checks++;
         if (running !== (i < 6) || done !== (i == 6)) begin
            errors++; $display("[TB] FAIL countdown_flags tick %0d got run=%b done=%b want run=%b done=%b", i, running, done, i < 6, i == 6);
         end
         if (i == 3 || i == 5) begin
            step(0, 0, 0, 0, 0);
            checks++;
            if (framebuf !== ((i == 3) ? want3 : want5)) begin
               errors++; $display("[TB] FAIL countdown_fb tick %0d got %h want %h", i, framebuf, (i == 3) ? want3 : want5);
            end
         end
      end
      step(0, 0, 0, 0, 0);
      checks++;
      if (framebuf !== wantAll1) begin errors++; $display("[TB] FAIL done_display got %h want %h", framebuf, wantAll1); end
   endtask

   task automatic test_pause();
      logic [N*24-1:0] want2;
      want2 = {48'h0, 24'hFF0000, 24'hFF0000};
      step(1, 0, 0, 0, 4'd6);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 1, 0, 0);
      checks++;
      if (running !== 1'b0) begin errors++; $display("[TB] FAIL pause_running got %b want 0", running); end
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 1, 0);
         checks++;
         if (framebuf !== want2) begin errors++; $display("[TB] FAIL pause_frozen tick %0d got %h want %h", i, framebuf, want2); end
      end
      step(0, 0, 1, 0, 0);
      checks++;
      if (running !== 1'b1) begin errors++; $display("[TB] FAIL resume_running got %b want 1", running); end
      for (int j = 1; j <= 4; j++) begin
         step(0, 0, 0, 1, 0);
         checks++;
         if (done !== (j == 4)) begin errors++; $display("[TB] FAIL resume_done tick %0d got %b want %b", j, done, j == 4); end
      end
   endtask

   task automatic test_blink();
      logic [N*24-1:0] wantAll1;
      wantAll1 = {12{8'h01}};
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      checks++;
      if (framebuf !== '0) begin errors++; $display("[TB] FAIL blink_phase1 got %h want 0", framebuf); end
      step(0, 0, 0, 1, 0);
      checks++;
      if (framebuf !== wantAll1) begin errors++; $display("[TB] FAIL blink_phase2 got %h want %h", framebuf, wantAll1); end
      step(0, 0, 0, 0, 0);
      checks++;
      if (framebuf !== '0) begin errors++; $display("[TB] FAIL blink_phase3 got %h want 0", framebuf); end
      step(0, 1, 0, 0, 0);
      checks++;
      if (done !== 1'b0 || running !== 1'b0) begin errors++; $display("[TB] FAIL stop_flags got run=%b done=%b want 00", running, done); end
      step(0, 0, 0, 0, 0);
      checks++;
      if (framebuf !== '0) begin errors++; $display("[TB] FAIL stop_fb got %h want 0", framebuf); end
   endtask

   task automatic test_back_to_back();
      logic [N*24-1:0] want1, wantAll1;
      want1    = {72'h0, 24'hFF0000};
      wantAll1 = {12{8'h01}};
      step(1, 0, 0, 0, 4'd10);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
      step(1, 0, 0, 1, 4'd10);
      checks++;
      if (running !== 1'b1) begin errors++; $display("[TB] FAIL restart_running got %b want 1", running); end
      step(0, 0, 0, 0, 0);
      checks++;
      if (framebuf !== '0) begin errors++; $display("[TB] FAIL restart_cleared got %h want 0", framebuf); end
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      checks++;
      if (framebuf !== want1) begin errors++; $display("[TB] FAIL restart_count got %h want %h", framebuf, want1); end
      step(1, 0, 0, 0, 4'd0);
      checks++;
      if (done !== 1'b1 || running !== 1'b0) begin errors++; $display("[TB] FAIL zero_target got run=%b done=%b want run=0 done=1", running, done); end
      step(0, 0, 0, 0, 0);
      checks++;
      if (framebuf !== wantAll1) begin errors++; $display("[TB] FAIL zero_target_fb got %h want %h", framebuf, wantAll1); end
   endtask

   task automatic test_reset_midrun();
      step(1, 0, 0, 0, 4'd12);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
      nrst = 0;
      step(0, 0, 0, 0, 0);
      checks++;
      if (running !== 1'b0 || done !== 1'b0 || framebuf !== '0) begin
         errors++; $display("[TB] FAIL midrun_reset got run=%b done=%b fb=%h want all 0", running, done, framebuf);
      end
      nrst = 1;
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 1, 0);
         checks++;
         if (running !== 1'b0 || done !== 1'b0 || framebuf !== '0) begin
            errors++; $display("[TB] FAIL post_reset_tick %0d got run=%b done=%b fb=%h want all 0", i, running, done, framebuf);
         end
      end
   endtask

   task automatic test_random();
      bit st, sp, pa, tk;
      logic [TW-1:0] tg;
      for (int c = 0; c < 600; c++) begin
         nrst = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
         sp = ($urandom_range(99) < 3);
         st = ($urandom_range(99) < 7);
         pa = ($urandom_range(99) < 8);
         tk = ($urandom_range(99) < 45);
         tg = ($urandom_range(9) == 0) ? 4'd0 : 4'($urandom_range(15));
         step(st, sp, pa, tk, tg);
         checks += 3;
         if (running !== (mActive && !mPaused)) begin errors++; $display("[TB] FAIL rand_running cycle %0d got %b want %b", c, running, mActive && !mPaused); end
         if (done !== mFinished) begin errors++; $display("[TB] FAIL rand_done cycle %0d got %b want %b", c, done, mFinished); end
         if (framebuf !== mFb) begin errors++; $display("[TB] FAIL rand_fb cycle %0d got %h want %h", c, framebuf, mFb); end
      end
      nrst = 1;
   endtask

   initial begin
      nrst = 0; tick = 0; swStart = 0; swStop = 0; swPause = 0; target = '0;
      mActive = 0; mPaused = 0; mFinished = 0; mPh = 1; mEl = 0; mTgt = 0; mFb = '0;
      @(negedge clk);
      test_reset();
      test_countdown();
      test_pause();
      test_blink();
      test_back_to_back();
      test_reset_midrun();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/teatimer_gen.md
TEATIMER_GEN -- requirements
Module: teatimer_gen

Interface
REQ-001 SHALL have parameter NLED, default 16, meaning the pixel count; legal values are 4, 8, 16, 32 and 64.
REQ-002 SHALL have parameter LEVEL, default 255, meaning the byte value of a lit progress sub-pixel.
REQ-003 SHALL have parameter DONE_LEVEL, default 1, meaning the byte value of every sub-pixel while the done display is lit.
REQ-004 SHALL have parameter BLINK, default 1, meaning the done display blinks when 1 and is steady when 0.
REQ-005 SHALL derive localparam TW = 2*log2(NLED), the width of the elapsed and target values.
REQ-006 SHALL have port clk, input, 1 bit: the system clock.
REQ-007 SHALL have port nrst, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have port tick, input, 1 bit: a one-clk strobe, nominally 1 Hz.
REQ-009 SHALL have port sw_start, input, 1 bit: start/restart, sampled each clk.
REQ-010 SHALL have port sw_stop, input, 1 bit: abort to IDLE.
REQ-011 SHALL have port sw_pause, input, 1 bit: a one-clk pulse that toggles RUN/PAUSE.
REQ-012 SHALL have port target, input, TW bits: brew duration in ticks, latched at start.
REQ-013 SHALL have port framebuf, output reg, NLED*24 bits: pixel k occupies bits [24k+23:24k], with G at byte 0, R at byte 1 and B at byte 2.
REQ-014 SHALL have port running, output reg, 1 bit: high in RUN.
REQ-015 SHALL have port done, output reg, 1 bit: high in DONE.

Function
REQ-016 SHALL implement states IDLE, RUN, PAUSE and DONE, with registers elapsed[TW-1:0], tgt[TW-1:0] and blink phase ph.
REQ-017 SHALL evaluate inputs each clk with priority sw_stop > sw_start > sw_pause > tick; a lower-priority input arriving in the same cycle is discarded.
REQ-018 SHALL, on sw_stop in any state, enter IDLE and clear elapsed to 0.
REQ-019 SHALL, on sw_start in any state, latch tgt=target, clear elapsed=0, set ph=1 and enter RUN; if target==0, it SHALL enter DONE instead.
REQ-020 SHALL, on sw_pause, move RUN->PAUSE and PAUSE->RUN, and SHALL ignore sw_pause in IDLE and DONE.
REQ-021 SHALL, on tick in RUN, increment elapsed, and SHALL enter DONE in the same update when elapsed+1 == tgt.
REQ-022 SHALL ignore tick in IDLE and PAUSE, leaving elapsed frozen.
REQ-023 SHALL, on tick in DONE with BLINK=1, toggle ph; with BLINK=0, ph SHALL stay 1.
REQ-024 SHALL remain in DONE until sw_stop or sw_start, with elapsed held at tgt.
REQ-025 SHALL never wrap elapsed, since elapsed <= tgt <= 2^TW-1 and DONE halts counting.
REQ-026 SHALL compute fine = elapsed[log2(NLED)-1:0] and coarse = elapsed[TW-1:log2(NLED)].
REQ-027 SHALL register framebuf from the state and elapsed of the previous cycle, giving one clk of latency after a state/elapsed update.
REQ-028 SHALL drive framebuf to all zeros in IDLE.
REQ-029 SHALL, in RUN and PAUSE, set B of pixel k = LEVEL when k < fine, G of pixel k = LEVEL when k < coarse, and all other bytes, including every R byte, to 0.
REQ-030 SHALL, in DONE, set every byte of every pixel to DONE_LEVEL when ph==1 and to 0 when ph==0.
REQ-031 SHALL drive running and done as registered decodes of state, aligned with the state register and not with framebuf.

Reset
REQ-032 SHALL, on nrst==0 at a clk edge, set state=IDLE, elapsed=0, tgt=0, ph=1, framebuf=0, running=0 and done=0.
REQ-033 SHALL give reset priority over all other inputs, and SHALL take it in any state including mid-RUN and DONE.
REQ-034 SHALL exit reset into IDLE, with no output change until sw_start.

Verification
REQ-035 Bench with NLED=4, TW=4: target=6, pulse sw_start, 6 ticks -> running=1 through tick 5; done=1 after tick 6; done display (all bytes 1) on the next clk.
REQ-036 Same setup, after 5 ticks -> framebuf holds B of pixel 0 = 255 and G of pixel 0 = 255, all other bytes 0; after tick 3 -> B of pixels 0..2 = 255 and G all 0.
REQ-037 sw_pause after 2 ticks, then 5 ticks, then sw_pause again, then 4 ticks -> elapsed stays 2 while paused; done is asserted on the 4th tick after resume.
REQ-038 In DONE with BLINK=1, 3 ticks -> framebuf alternates all-0, all-1, all-0; then sw_stop -> IDLE, framebuf=0 one clk later.
REQ-039 sw_start and tick asserted in the same clk while in RUN with elapsed=3 -> elapsed=0, state RUN; sw_start with target=0 -> done=1 on the next clk.
REQ-040 nrst=0 asserted mid-RUN with elapsed=5 -> all outputs 0 and state IDLE on the next clk; ticks after release are ignored.
